// File: rtl/quad_resampler.sv
// Quadrilateral-to-rectangle resampler: walks an OUT_W x OUT_H raster, maps each pixel
// through bilinear edge interpolation and copies it from the source to the destination BRAM.
// Optional RESAMPLE_CLAMP_EN clamps out-of-frame coordinates instead of blanking them.
module quad_resampler #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int LOG_W = 6,
  parameter int LOG_H = 6,
  parameter int CW    = 10,
  parameter int FRAC  = 8,
  parameter int PW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CW-1:0]          tl_x,
  input  logic [CW-1:0]          tl_y,
  input  logic [CW-1:0]          tr_x,
  input  logic [CW-1:0]          tr_y,
  input  logic [CW-1:0]          bl_x,
  input  logic [CW-1:0]          bl_y,
  input  logic [CW-1:0]          br_x,
  input  logic [CW-1:0]          br_y,
  output logic                   busy,
  output logic                   done,
  output logic                   src_rd,
  output logic [16:0]            src_addr,
  input  logic [PW-1:0]          src_data,
  output logic                   dst_we,
  output logic [LOG_W+LOG_H-1:0] dst_addr,
  output logic [PW-1:0]          dst_data,
  output logic [2:0]             dbg_state
);
  localparam int AW    = CW + FRAC + 2;
  localparam int OUT_W = 1 << LOG_W;
  localparam int OUT_H = 1 << LOG_H;
  localparam logic signed [AW-1:0] XMAX = AW'(SRC_W - 1);
  localparam logic signed [AW-1:0] YMAX = AW'(SRC_H - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ROW, PIX, DRAIN, DONE} state_t;
  state_t state;

  logic [CW-1:0] ctl_x, ctl_y, ctr_x, ctr_y, cbl_x, cbl_y, cbr_x, cbr_y;
  logic signed [AW-1:0] lx, ly, rx, ry, dlx, dly, drx, dry;
  logic signed [AW-1:0] px, py, dpx, dpy;
  logic [LOG_H-1:0] r;
  logic [LOG_W-1:0] c;
  logic drain_cnt;
  logic v0, v1, rd1, rd2;
  logic [LOG_W+LOG_H-1:0] rc0, rc1;

  function automatic logic signed [AW-1:0] fx(input logic [CW-1:0] v);
    return $signed({2'b00, v, {FRAC{1'b0}}});
  endfunction

  // Address generation for the next pixel: the row start in ROW, the running P in PIX.
  logic signed [AW-1:0] cx, cy, ix, iy, dpx_row, dpy_row;
  logic x_lo, x_hi, y_lo, y_hi, in_range, rd_next;
  logic [16:0] sx, sy, addr_next;

  always_comb begin
    cx       = (state == ROW) ? lx : px;
    cy       = (state == ROW) ? ly : py;
    ix       = cx >>> FRAC;
    iy       = cy >>> FRAC;
    x_lo     = ix < 0;
    x_hi     = ix > XMAX;
    y_lo     = iy < 0;
    y_hi     = iy > YMAX;
    in_range = !(x_lo || x_hi || y_lo || y_hi);
`ifdef RESAMPLE_CLAMP_EN
    sx       = x_lo ? 17'd0 : (x_hi ? XMAX[16:0] : ix[16:0]);
    sy       = y_lo ? 17'd0 : (y_hi ? YMAX[16:0] : iy[16:0]);
    rd_next  = 1'b1;
`else
    sx       = ix[16:0];
    sy       = iy[16:0];
    rd_next  = in_range;
`endif
    addr_next = sy * 17'(SRC_W) + sx;
    dpx_row   = (rx - lx) >>> LOG_W;
    dpy_row   = (ry - ly) >>> LOG_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0;
      src_rd <= 1'b0; src_addr <= '0; v0 <= 1'b0; rc0 <= '0;
      ctl_x <= '0; ctl_y <= '0; ctr_x <= '0; ctr_y <= '0;
      cbl_x <= '0; cbl_y <= '0; cbr_x <= '0; cbr_y <= '0;
      lx <= '0; ly <= '0; rx <= '0; ry <= '0;
      dlx <= '0; dly <= '0; drx <= '0; dry <= '0;
      px <= '0; py <= '0; dpx <= '0; dpy <= '0;
      r <= '0; c <= '0; drain_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ctl_x <= tl_x; ctl_y <= tl_y; ctr_x <= tr_x; ctr_y <= tr_y;
          cbl_x <= bl_x; cbl_y <= bl_y; cbr_x <= br_x; cbr_y <= br_y;
          busy  <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          lx <= fx(ctl_x); ly <= fx(ctl_y);
          rx <= fx(ctr_x); ry <= fx(ctr_y);
          dlx <= (fx(cbl_x) - fx(ctl_x)) >>> LOG_H;
          dly <= (fx(cbl_y) - fx(ctl_y)) >>> LOG_H;
          drx <= (fx(cbr_x) - fx(ctr_x)) >>> LOG_H;
          dry <= (fx(cbr_y) - fx(ctr_y)) >>> LOG_H;
          r <= '0;
          state <= ROW;
        end
        ROW: begin
          // Pixel 0 is issued from here; P then tracks the pixel after the one on the bus.
          src_rd <= rd_next; src_addr <= addr_next;
          v0 <= 1'b1; rc0 <= {r, LOG_W'(0)};
          px <= lx + dpx_row; py <= ly + dpy_row;
          dpx <= dpx_row; dpy <= dpy_row;
          c <= '0;
          state <= PIX;
        end
        PIX: begin
          if (c == LOG_W'(OUT_W - 1)) begin
            src_rd <= 1'b0; v0 <= 1'b0;
            lx <= lx + dlx; ly <= ly + dly;
            rx <= rx + drx; ry <= ry + dry;
            r <= r + 1'b1;
            drain_cnt <= 1'b0;
            state <= (r == LOG_H'(OUT_H - 1)) ? DRAIN : ROW;
          end else begin
            src_rd <= rd_next; src_addr <= addr_next;
            v0 <= 1'b1; rc0 <= {r, c + 1'b1};
            px <= px + dpx; py <= py + dpy;
            c <= c + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            done <= 1'b1; busy <= 1'b0;
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage pixel pipe aligned with the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; rc1 <= '0; rd1 <= 1'b0;
      dst_we <= 1'b0; dst_addr <= '0; rd2 <= 1'b0;
    end else begin
      v1 <= v0; rc1 <= rc0; rd1 <= src_rd;
      dst_we <= v1; dst_addr <= rc1; rd2 <= rd1;
    end
  end

  assign dst_data  = (dst_we && rd2) ? src_data : '0;
  assign dbg_state = state;
endmodule

// File: tb/tb_quad_resampler.sv
// Directed bench for quad_resampler: scoreboard of expected reads/writes built from the
// bilinear mapping, a 2-cycle-latency source BRAM model and a cycle-accurate monitor.
module tb_quad_resampler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  tl_x = '0, tl_y = '0, tr_x = '0, tr_y = '0;
  logic [9:0]  bl_x = '0, bl_y = '0, br_x = '0, br_y = '0;
  logic        busy, done, src_rd, dst_we;
  logic [16:0] src_addr;
  logic [7:0]  src_data = '0;
  logic [11:0] dst_addr;
  logic [7:0]  dst_data;
  logic [2:0]  dbg_state;

  quad_resampler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
    .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y),
    .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr),
    .src_data(src_data), .dst_we(dst_we), .dst_addr(dst_addr),
    .dst_data(dst_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // source BRAM: pixel value = address mod 256, data two cycles after the address
  logic [16:0] a1 = '0;
  logic        r1 = 1'b0;
  always @(posedge clk) begin
    a1 <= src_addr;
    r1 <= src_rd;
    src_data <= r1 ? a1[7:0] : 8'($urandom_range(255, 0));
  end

  // scoreboard
  logic [32:0] rd_q[$];   // {cycle, src_addr}
  logic [35:0] dst_q[$];  // {cycle, dst_addr, dst_data}
  int n_cmp = 0, n_bad = 0;
  int n0 = 0, exp_done = -1, done_cnt = 0, rd_cnt = 0;
  logic [16:0] obs_addr[4096];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int k[8]);
    int lx, ly, rx, ry, dlx, dly, drx, dry, px, py, dpx, dpy, x, y, addr, cyc;
    bit inr, rd;
    lx = k[0] * 256; ly = k[1] * 256; rx = k[2] * 256; ry = k[3] * 256;
    dlx = ((k[4] - k[0]) * 256) >>> 6; dly = ((k[5] - k[1]) * 256) >>> 6;
    drx = ((k[6] - k[2]) * 256) >>> 6; dry = ((k[7] - k[3]) * 256) >>> 6;
    for (int r = 0; r < 64; r++) begin
      dpx = (rx - lx) >>> 6; dpy = (ry - ly) >>> 6;
      px = lx; py = ly;
      for (int c = 0; c < 64; c++) begin
        x = px >>> 8; y = py >>> 8;
        inr = (x >= 0) && (x < 320) && (y >= 0) && (y < 240);
`ifdef RESAMPLE_CLAMP_EN
        if (x < 0) x = 0; if (x > 319) x = 319;
        if (y < 0) y = 0; if (y > 239) y = 239;
        rd = 1'b1;
`else
        rd = inr;
`endif
        addr = y * 320 + x;
        cyc = 3 + r * 65 + c;
        if (rd) rd_q.push_back({16'(cyc), 17'(addr)});
        dst_q.push_back({16'(cyc + 2), 6'(r), 6'(c), rd ? 8'(addr) : 8'd0});
        px += dpx; py += dpy;
      end
      lx += dlx; ly += dly; rx += drx; ry += dry;
    end
    exp_done = 64 * 65 + 4;
  endtask

  // monitor: cycle k is the interval ending at the k-th edge after the accepted start
  always @(negedge clk) if (rst_n) begin
    int rel, p;
    logic [32:0] er;
    logic [35:0] ed;
    rel = ecnt - n0 + 1;
    if (src_rd) begin
      rd_cnt++;
      p = rel - 3;
      if (p >= 0 && p < 64 * 65 && (p % 65) < 64) obs_addr[(p / 65) * 64 + (p % 65)] = src_addr;
      n_cmp++;
      assert (rd_q.size() != 0) else begin
        n_bad++;
        $error("FAIL rd_extra: observed addr %0d at cycle %0d expected none", src_addr, rel);
      end
      if (rd_q.size() != 0) begin
        er = rd_q.pop_front();
        check("src_rd_cyc_addr", {16'(rel), src_addr}, er);
      end
    end
    if (dst_we) begin
      n_cmp++;
      assert (dst_q.size() != 0) else begin
        n_bad++;
        $error("FAIL dst_extra: observed addr %0h at cycle %0d expected none", dst_addr, rel);
      end
      if (dst_q.size() != 0) begin
        ed = dst_q.pop_front();
        check("dst_cyc_addr_data", {16'(rel), dst_addr, dst_data}, ed);
      end
    end
    if (done) begin
      done_cnt++;
      check("done_cycle", rel, exp_done);
      check("busy_low_at_done", busy, 1'b0);
      exp_done = -1;
    end
  end

  // driver tasks
  task automatic set_corners(input int k[8]);
    tl_x = 10'(k[0]); tl_y = 10'(k[1]); tr_x = 10'(k[2]); tr_y = 10'(k[3]);
    bl_x = 10'(k[4]); bl_y = 10'(k[5]); br_x = 10'(k[6]); br_y = 10'(k[7]);
  endtask

  task automatic do_start(input int k[8]);
    @(negedge clk);
    set_corners(k);
    push_frame(k);
    rd_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1 n0 = ecnt;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1'b1);
    check("state_setup", dbg_state, 3'd1);
  endtask

  task automatic wait_done();
    int want, i;
    want = done_cnt + 1;
    i = 0;
    while (done_cnt < want && i < 5000) begin
      @(negedge clk);
      #2 i++;
    end
    check("done_seen", done_cnt, want);
    check("rd_q_drained", rd_q.size(), 0);
    check("dst_q_drained", dst_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, done, src_rd, dst_we, src_addr, dst_addr, dst_data, dbg_state}, '0);
  endtask

  int ident[8] = '{0, 0, 64, 0, 0, 64, 64, 64};
  int scale[8] = '{10, 20, 138, 20, 10, 148, 138, 148};
  int skew[8]  = '{100, 50, 200, 60, 90, 150, 210, 170};
  int oor[8]   = '{0, 0, 360, 0, 0, 64, 360, 64};

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity
    do_start(ident);
    wait_done();
    check("ident_r5c7", obs_addr[5 * 64 + 7], 17'(5 * 320 + 7));
    check("ident_r63c63", obs_addr[63 * 64 + 63], 17'(63 * 320 + 63));

    // start one cycle after done, 2x scale
    do_start(scale);
    wait_done();
    check("scale_r0c1", obs_addr[1], 17'(20 * 320 + 12));
    check("scale_r63c63", obs_addr[63 * 64 + 63], 17'(146 * 320 + 136));

    // skew with an ignored start at cycle 1000
    repeat (4) @(negedge clk);
    do_start(skew);
    repeat (999) @(negedge clk);
    set_corners(ident);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_ignored_start", busy, 1'b1);
    wait_done();
    check("skew_r0c32", obs_addr[32], 17'(55 * 320 + 150));
    check("skew_r32c0", obs_addr[32 * 64], 17'(100 * 320 + 95));

    // reset mid-frame
    repeat (4) @(negedge clk);
    do_start(ident);
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    rd_q.delete();
    dst_q.delete();
    exp_done = -1;
    dc = done_cnt;
    #1 check_all_zero("reset_mid_frame");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_reset", done_cnt, dc);
    do_start(scale);
    wait_done();
    check("post_reset_r63c63", obs_addr[63 * 64 + 63], 17'(146 * 320 + 136));

    // out-of-range right edge
    repeat (4) @(negedge clk);
    do_start(oor);
    wait_done();
`ifdef RESAMPLE_CLAMP_EN
    check("oor_read_count", rd_cnt, 4096);
    check("oor_r10c63_clamped", obs_addr[10 * 64 + 63], 17'(10 * 320 + 319));
`else
    check("oor_read_count", rd_cnt, 64 * 57);
    check("oor_r10c56", obs_addr[10 * 64 + 56], 17'(10 * 320 + 315));
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
